// File: rtl/mem_bus_bridge.sv
// MEM-stage to req/ack data-bus bridge: one outstanding access, stalls the pipeline
// until completion, and flags misaligned or timed-out accesses.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        mem_adv,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] err_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             acc;

  assign acc       = mem_ren | mem_wen;
  assign mem_stall = ((state == IDLE) && acc) || (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_din   <= '0;
      mem_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            if (mem_addr[1:0] == 2'b00) begin
              bus_req   <= 1'b1;
              bus_we    <= mem_wen;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_dout;
              count     <= '0;
              state     <= BUSY;
            end else begin
              mem_din  <= '0;
              err_addr <= mem_addr;
              mem_err  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          // Direction comes from the latched bus_we, not the live MEM-stage inputs.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) mem_din <= bus_rdata;
            state <= DONE;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            bus_req  <= 1'b0;
            mem_din  <= '0;
            err_addr <= bus_addr;
            mem_err  <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          if (mem_adv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: scoreboard of expected bus transactions
// plus a small model of mem_din / mem_err / err_addr.
module tb_mem_bus_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen, mem_adv;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, mem_err;
  logic [31:0] err_addr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          req_starts = 0;
  int          exp_starts = 0;
  logic [31:0] exp_din = '0;

  mem_bus_bridge #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_adv(mem_adv), .mem_din(mem_din), .mem_stall(mem_stall), .mem_err(mem_err),
    .err_addr(err_addr), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge bus_req) req_starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MEM-stage access: ack_at = BUSY cycle that acks (0 = never),
  // hold = DONE cycles with mem_adv low (a stray ack is driven in the 2nd one).
  task automatic access(input logic wen_i, input logic ren_i, input logic [31:0] addr,
                        input logic [31:0] dout, input int ack_at,
                        input logic [31:0] rdata, input int hold);
    txn_t t, got;
    int   stall_n, req_n, exp_stall, exp_req;
    logic aligned, tmo, err;
    aligned = (addr[1:0] == 2'b00);
    tmo     = aligned && (ack_at == 0 || ack_at > TMO);
    err     = !aligned || tmo;
    mem_wen = wen_i; mem_ren = ren_i; mem_addr = addr; mem_dout = dout;
    mem_adv = 1'b0;  bus_ack = 1'b0;
    if (aligned) begin
      t.we = wen_i; t.addr = addr; t.wdata = dout;
      sb.push_back(t);
      exp_starts++;
    end
    stall_n = 0; req_n = 0;
    #1;
    for (int cyc = 0; cyc < 40 && mem_stall; cyc++) begin
      stall_n++;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
          end else begin
            got = sb.pop_front();
            check("bus_we",    {31'd0, bus_we}, {31'd0, got.we});
            check("bus_addr",  bus_addr, got.addr);
            check("bus_wdata", bus_wdata, got.wdata);
          end
          mem_addr = ~addr;
          mem_dout = ~dout;
        end else begin
          check("bus_addr_stable", bus_addr, addr);
        end
        bus_ack   = (req_n == ack_at);
        bus_rdata = bus_ack ? rdata : $urandom;
      end
      tick();
      bus_ack = 1'b0;
      #1;
    end
    exp_stall = !aligned ? 1 : (tmo ? TMO + 1 : ack_at + 1);
    exp_req   = !aligned ? 0 : (tmo ? TMO : ack_at);
    if (err) exp_din = '0;
    else if (!wen_i) exp_din = rdata;
    check("done_stall",   {31'd0, mem_stall}, 32'd0);
    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    check("req_cycles",   32'(req_n), 32'(exp_req));
    check("done_req",     {31'd0, bus_req}, 32'd0);
    check("err_pulse",    {31'd0, mem_err}, {31'd0, err});
    check("mem_din",      mem_din, exp_din);
    if (err) check("err_addr", err_addr, addr);
    for (int h = 0; h < hold; h++) begin
      bus_ack   = (h == 1);
      bus_rdata = $urandom;
      tick();
      bus_ack = 1'b0;
      #1;
      check("hold_err",   {31'd0, mem_err}, 32'd0);
      check("hold_stall", {31'd0, mem_stall}, 32'd0);
      check("hold_req",   {31'd0, bus_req}, 32'd0);
      check("hold_din",   mem_din, exp_din);
    end
    mem_adv = 1'b1;
    tick();
    mem_adv = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    #1;
    check("idle_stall", {31'd0, mem_stall}, 32'd0);
    check("idle_err",   {31'd0, mem_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_adv = 1'b0;
    mem_addr = '0; mem_dout = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    check("rst_req",   {31'd0, bus_req}, 32'd0);
    check("rst_we",    {31'd0, bus_we}, 32'd0);
    check("rst_err",   {31'd0, mem_err}, 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_din",   mem_din, 32'd0);
    check("rst_eaddr", err_addr, 32'd0);
    rst = 1'b0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    check("idle_ack_din", mem_din, 32'd0);
    check("idle_ack_req", {31'd0, bus_req}, 32'd0);

    access(1'b0, 1'b1, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 3);
    access(1'b1, 1'b0, 32'h0000_0024, 32'h1234_5678, 1, 32'h5555_AAAA, 0);
    access(1'b0, 1'b1, 32'h0000_0013, 32'h0,         1, 32'h7777_7777, 1);
    access(1'b0, 1'b1, 32'h0000_0030, 32'h0,         0, 32'h0,         3);
    access(1'b0, 1'b1, 32'h0000_0040, 32'h0,         2, 32'hCAFE_F00D, 0);
    access(1'b1, 1'b0, 32'h0000_0044, 32'hA5A5_0044, 2, 32'h0BAD_0BAD, 0);
    check("b2b_starts", 32'(req_starts), 32'(exp_starts));
    access(1'b1, 1'b1, 32'h0000_0048, 32'h0F0F_0048, 1, 32'h1111_2222, 0);

    mem_ren = 1'b1; mem_addr = 32'h0000_0060;
    sb.push_back('{we: 1'b0, addr: 32'h0000_0060, wdata: mem_dout});
    exp_starts++;
    tick();
    check("rstbusy_req", {31'd0, bus_req}, 32'd1);
    if (sb.size() != 0) void'(sb.pop_front());
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp_din = '0;
    check("rstbusy_req_drop", {31'd0, bus_req}, 32'd0);
    check("rstbusy_din",      mem_din, 32'd0);
    check("rstbusy_addr",     bus_addr, 32'd0);
    mem_ren = 1'b0;
    #1;
    check("rstbusy_idle", {31'd0, mem_stall}, 32'd0);
    tick();
    rst = 1'b0;
    access(1'b0, 1'b1, 32'h0000_0080, 32'h0, 1, 32'h8080_8080, 0);
    check("total_starts", 32'(req_starts), 32'(exp_starts));
    check("sb_drained",   32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
